// File: rtl/sync_fifo_pkg.sv
// Shared sizing, default thresholds and types for the 24-bit x 16-entry sync FIFO.
package sync_fifo_pkg;
  localparam int DATA_W             = 24;
  localparam int DEPTH              = 16;
  localparam int PTR_W              = $clog2(DEPTH);
  localparam int CNT_W              = PTR_W + 1;
  localparam int ALMST_EMPTY_TH_DEF = 2;
  localparam int ALMST_FULL_TH_DEF  = 14;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;
endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer side of the FIFO: write/read handshake, data and status.
// master = the client driving requests, slave = the FIFO itself.
interface sync_fifo_if;
  import sync_fifo_pkg::*;

  word_t data_in;
  logic  wr_en;
  logic  rd_en;
  word_t data_out;
  cnt_t  data_count;
  logic  empty;
  logic  full;
  logic  almst_empty;
  logic  almst_full;
  logic  err;

  modport master (
    output data_in, wr_en, rd_en,
    input  data_out, data_count, empty, full, almst_empty, almst_full, err
  );

  modport slave (
    input  data_in, wr_en, rd_en,
    output data_out, data_count, empty, full, almst_empty, almst_full, err
  );
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array with one write port and one registered read port.
// Storage is never cleared; only the read register returns to zero on reset.
module fifo_mem
  import sync_fifo_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  we,
  input  ptr_t  waddr,
  input  word_t wdata,
  input  logic  re,
  input  ptr_t  raddr,
  output word_t rdata
);

  word_t mem [DEPTH];

  // write port: storage has no reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read port: holds its value when no read is accepted
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count, flag decode and error report.
// Build option: define FIFO_STICKY_ERR_EN to make err sticky until reset;
// by default err is a one-cycle pulse following each rejected access.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int ALMST_EMPTY_TH = ALMST_EMPTY_TH_DEF,
  parameter int ALMST_FULL_TH  = ALMST_FULL_TH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  sync_fifo_if.slave  bus
);

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  cnt_t count;
  logic err_q;

  logic is_empty;
  logic is_full;
  logic wr_ok;
  logic rd_ok;
  logic reject;

  assign is_empty = (count == '0);
  assign is_full  = (count == cnt_t'(DEPTH));

  // a full FIFO still takes a write when a read frees a slot in the same cycle
  assign rd_ok  = bus.rd_en & ~is_empty;
  assign wr_ok  = bus.wr_en & (~is_full | bus.rd_en);
  assign reject = (bus.wr_en & is_full & ~bus.rd_en) | (bus.rd_en & is_empty);

  fifo_mem u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (wr_ok & ~reset),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .re    (rd_ok),
    .raddr (rd_ptr),
    .rdata (bus.data_out)
  );

  // pointers wrap naturally at DEPTH; count follows accepted accesses only
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ptr_t'(1);
      if (rd_ok) rd_ptr <= rd_ptr + ptr_t'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  // error flag: registered report of a rejected access
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
`ifdef FIFO_STICKY_ERR_EN
      err_q <= err_q | reject;
`else
      err_q <= reject;
`endif
    end
  end

  assign bus.data_count  = count;
  assign bus.empty       = is_empty;
  assign bus.full        = is_full;
  assign bus.almst_empty = (count <= cnt_t'(ALMST_EMPTY_TH));
  assign bus.almst_full  = (count >= cnt_t'(ALMST_FULL_TH));
  assign bus.err         = err_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: the driver pushes the expected data_out for
// every issued read; a monitor pops and compares one cycle later.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sync_fifo_if bus();

  sync_fifo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  word_t sb_q[$];   // expected data_out, one entry per issued read
  word_t mq[$];     // reference contents
  word_t mlast;     // reference data_out
  word_t sb_e;
  int    mcnt;
  logic  merr;
  logic  rd_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: a read sampled at an edge shows its data before the next edge
  always @(posedge clk) rd_seen <= bus.rd_en & ~reset;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (sb_q.size() == 0) begin
        chk("sb_underrun", 32'd1, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        chk("data_out", 32'(bus.data_out), 32'(sb_e));
      end
    end
  end

  task automatic chk_status();
    chk("data_count",  32'(bus.data_count),  32'(mcnt));
    chk("empty",       32'(bus.empty),       32'(mcnt == 0));
    chk("full",        32'(bus.full),        32'(mcnt == DEPTH));
    chk("almst_empty", 32'(bus.almst_empty), 32'(mcnt <= 2));
    chk("almst_full",  32'(bus.almst_full),  32'(mcnt >= 14));
    chk("err",         32'(bus.err),         32'(merr));
  endtask

  task automatic op(input logic wr, input logic rd, input word_t din);
    logic rej;
    rej = (wr && !rd && mcnt == DEPTH) || (rd && mcnt == 0);
    if (rd && mcnt > 0) begin
      mlast = mq.pop_front();
      mcnt--;
    end
    if (rd) sb_q.push_back(mlast);
    if (wr && mcnt < DEPTH) begin
      mq.push_back(din);
      mcnt++;
    end
`ifdef FIFO_STICKY_ERR_EN
    merr = merr | rej;
`else
    merr = rej;
`endif
    bus.wr_en   = wr;
    bus.rd_en   = rd;
    bus.data_in = din;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    chk_status();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mq.delete();
    mcnt  = 0;
    mlast = '0;
    merr  = 1'b0;
    chk_status();
    chk("rst_data_out", 32'(bus.data_out), 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.data_in = '0;
    mcnt = 0; mlast = '0; merr = 1'b0;

    // 1: fill 0..15 one per two cycles, then overflow with 16
    do_reset();
    for (int i = 0; i < 16; i++) begin
      op(1'b1, 1'b0, word_t'(i));
      op(1'b0, 1'b0, '0);
    end
    chk("t1_count", 32'(bus.data_count), 32'd16);
    chk("t1_full",  32'(bus.full),       32'd1);
    op(1'b1, 1'b0, word_t'(16));
    chk("t1_ovf_err",   32'(bus.err),        32'd1);
    chk("t1_ovf_count", 32'(bus.data_count), 32'd16);
    op(1'b0, 1'b0, '0);

    // 2: drain 16 then underflow; data_out stays 15
    for (int i = 0; i < 17; i++) op(1'b0, 1'b1, '0);
    chk("t2_empty",    32'(bus.empty),    32'd1);
    chk("t2_udf_err",  32'(bus.err),      32'd1);
    chk("t2_data_out", 32'(bus.data_out), 32'd15);

    // 3: write 0..14, read 11 -> 0..10, count 4
    do_reset();
    for (int i = 0; i < 15; i++) op(1'b1, 1'b0, word_t'(i));
    for (int i = 0; i < 11; i++) op(1'b0, 1'b1, '0);
    chk("t3_data_out",    32'(bus.data_out),    32'd10);
    chk("t3_count",       32'(bus.data_count),  32'd4);
    chk("t3_almst_empty", 32'(bus.almst_empty), 32'd0);

    // 4: 11 simultaneous rd/wr, write pointer wraps
    for (int i = 0; i < 11; i++) op(1'b1, 1'b1, word_t'(i));
    chk("t4_count",    32'(bus.data_count), 32'd4);
    chk("t4_data_out", 32'(bus.data_out),   32'd6);

    // 5: rd&wr on empty -> write only, err
    for (int i = 0; i < 4; i++) op(1'b0, 1'b1, '0);
    op(1'b1, 1'b1, 24'hABCDEF);
    chk("t5_err",   32'(bus.err),        32'd1);
    chk("t5_count", 32'(bus.data_count), 32'd1);
    op(1'b0, 1'b1, '0);
    chk("t5_data_out", 32'(bus.data_out), 32'hABCDEF);

    // 6: reset with 9 stored words, then overflow and idle before a final reset
    for (int i = 0; i < 9; i++) op(1'b1, 1'b0, word_t'(100 + i));
    chk("t6_count9", 32'(bus.data_count), 32'd9);
    do_reset();
    chk("t6_rst_count", 32'(bus.data_count), 32'd0);
    chk("t6_rst_err",   32'(bus.err),        32'd0);
    for (int i = 0; i < 16; i++) op(1'b1, 1'b0, word_t'(200 + i));
    op(1'b1, 1'b0, word_t'(999));
    for (int i = 0; i < 3; i++) op(1'b0, 1'b0, '0);
`ifdef FIFO_STICKY_ERR_EN
    chk("t6_sticky_err", 32'(bus.err), 32'd1);
`else
    chk("t6_pulse_err",  32'(bus.err), 32'd0);
`endif
    op(1'b0, 1'b1, '0);
    chk("t6_first_out", 32'(bus.data_out), 32'd200);
    do_reset();

    @(posedge clk); #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
